memory_stage: RTL

Pipeline stage directly downstream of the execute stage. It accepts one instruction at a time through the done/stall handshake, issues a single data-memory request for loads and stores, and aligns and sign-extends load data. It then presents the writeback value (load data or execute result) to the writeback stage. Non-memory instructions pass through in one cycle without touching the bus.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/memory_stage_load_align.sv | 33 +++
 rtl/memory_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and helpers for the memory stage.
// Contents:
//   memory_stage_state_t  - stage FSM encoding
//   LS_*                  - funct3 load/store width codes
//   ls_width_ok()         - funct3 names a supported access width
//   ls_strobe()           - byte enables for a width at a lane offset
package cpu_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        REQUEST  = 2'd1,
        RESPONSE = 2'd2,
        FULL     = 2'd3
    } memory_stage_state_t;

    localparam logic [2:0] LS_BYTE   = 3'b000;
    localparam logic [2:0] LS_HALF   = 3'b001;
    localparam logic [2:0] LS_WORD   = 3'b010;
    localparam logic [2:0] LS_BYTE_U = 3'b100;
    localparam logic [2:0] LS_HALF_U = 3'b101;

    // 011/110/111 are not valid access widths
    function automatic logic ls_width_ok(input logic [2:0] funct3);
        return (funct3 == LS_BYTE) || (funct3 == LS_HALF) || (funct3 == LS_WORD) ||
               (funct3 == LS_BYTE_U) || (funct3 == LS_HALF_U);
    endfunction

    // Offset is expected to be naturally aligned for the width already
    function automatic logic [3:0] ls_strobe(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] strobe;
        case (funct3[1:0])
            2'b00:   strobe = 4'b0001 << off;
            2'b01:   strobe = 4'b0011 << off;
            default: strobe = 4'b1111 << off;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// load_align: shifts the addressed lane of a load response down to bit 0 and
// sign- or zero-extends it according to funct3.
// Ports:
//   rdata        - raw load response word
//   off          - byte offset within the word (already naturally aligned)
//   funct3       - access width / signedness
//   load_value_c - extended load value (combinational)
module load_align
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            off,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] load_value_c
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted      = rdata >> {off, 3'b000};
        load_value_c = shifted;
        case (funct3)
            LS_BYTE:   load_value_c = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            LS_BYTE_U: load_value_c = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            LS_HALF:   load_value_c = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            LS_HALF_U: load_value_c = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default:   load_value_c = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage after execute. Issues one data-bus request for
// each load/store, aligns load data and presents the writeback value.
// Optional build macro: MEMORY_STAGE_MISALIGN_TRAP_EN - misaligned halfword/word
// accesses skip the bus and flag misaligned_out; otherwise the offset is
// truncated to natural alignment.
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   prev_done / stall_prev       - handshake with execute stage
//   done_next / next_stall       - handshake with writeback stage
//   *_in                         - execute-stage results, captured on transfer
//   mem_*                        - single-beat data bus (req/ready, rvalid/rdata)
//   *_out                        - values presented to writeback
module memory_stage
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH              = 32,
    parameter int unsigned DATA_WIDTH              = 32,
    parameter int unsigned REGISTER_INDEXING_WIDTH = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic                               stall_prev,
    input  logic                               prev_done,
    input  logic                               next_stall,
    output logic                               done_next,
    input  logic [ADDR_WIDTH-1:0]              program_count_in,
    input  logic                               program_count_valid_in,
    input  logic                               load_in,
    input  logic                               store_in,
    input  logic [2:0]                         funct_3_in,
    input  logic                               funct_3_valid_in,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
    input  logic                               write_register_valid_in,
    input  logic [DATA_WIDTH-1:0]              result_data_in,
    input  logic                               result_data_valid_in,
    input  logic [DATA_WIDTH-1:0]              memory_store_data_in,
    input  logic                               memory_store_data_valid_in,
    output logic                               mem_req,
    input  logic                               mem_ready,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic                               mem_we,
    output logic [3:0]                         mem_wstrb,
    output logic [DATA_WIDTH-1:0]              mem_wdata,
    input  logic                               mem_rvalid,
    input  logic [DATA_WIDTH-1:0]              mem_rdata,
    output logic [ADDR_WIDTH-1:0]              program_count_out,
    output logic                               program_count_valid_out,
    output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
    output logic                               write_register_valid_out,
    output logic [DATA_WIDTH-1:0]              write_data_out,
    output logic                               write_data_valid_out,
    output logic                               misaligned_out
);

    memory_stage_state_t state, state_next;

    logic                  accept_c;
    logic                  capture_c;
    logic                  access_c;
    logic                  misalign_c;
    logic                  to_bus_c;
    logic [1:0]            off_c;
    logic [1:0]            off_eff_c;
    logic [31:0]           wdata_c;
    logic [1:0]            off_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] load_value_c;
    logic                  unused_c;

    // Valid qualifiers for funct3 and store data carry no extra information here
    assign unused_c = ^{funct_3_valid_in, memory_store_data_valid_in};

    // Stage can take a new instruction this cycle
    assign accept_c   = (state == EMPTY) || ((state == FULL) && !next_stall);
    assign capture_c  = accept_c && prev_done;
    assign stall_prev = !rst_n || !accept_c;

    // Access classification of the incoming instruction
    assign off_c    = result_data_in[1:0];
    assign access_c = (load_in || store_in) && ls_width_ok(funct_3_in);
    assign to_bus_c = access_c && !misalign_c;

    // Offset rounded down to natural alignment; only matters without the trap
    always_comb begin
        off_eff_c = off_c;
        case (funct_3_in[1:0])
            2'b00:   off_eff_c = off_c;
            2'b01:   off_eff_c = {off_c[1], 1'b0};
            default: off_eff_c = 2'b00;
        endcase
    end

    // Replicating the store data fills every lane, so the lane shift is implicit
    always_comb begin
        wdata_c = memory_store_data_in[31:0];
        case (funct_3_in[1:0])
            2'b00:   wdata_c = {4{memory_store_data_in[7:0]}};
            2'b01:   wdata_c = {2{memory_store_data_in[15:0]}};
            default: wdata_c = memory_store_data_in[31:0];
        endcase
    end

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    assign misalign_c = access_c &&
                        (((funct_3_in[1:0] == 2'b01) && off_c[0]) ||
                         ((funct_3_in[1:0] == 2'b10) && (off_c != 2'b00)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_out <= 1'b0;
        end else if (capture_c) begin
            misaligned_out <= misalign_c;
        end
    end
`else
    assign misalign_c     = 1'b0;
    assign misaligned_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (capture_c) state_next = to_bus_c ? REQUEST : FULL;
            end
            REQUEST: begin
                if (mem_ready) state_next = mem_we ? FULL : RESPONSE;
            end
            RESPONSE: begin
                if (mem_rvalid) state_next = FULL;
            end
            FULL: begin
                if (!next_stall) begin
                    if (capture_c) state_next = to_bus_c ? REQUEST : FULL;
                    else           state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_next <= 1'b0;
            mem_req   <= 1'b0;
        end else begin
            done_next <= (state_next == FULL);
            mem_req   <= (state_next == REQUEST);
        end
    end

    load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .rdata       (mem_rdata),
        .off         (off_q),
        .funct3      (funct3_q),
        .load_value_c(load_value_c)
    );

    // Instruction capture, bus request fields and load writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            program_count_out        <= '0;
            program_count_valid_out  <= 1'b0;
            write_register_out       <= '0;
            write_register_valid_out <= 1'b0;
            write_data_out           <= '0;
            write_data_valid_out     <= 1'b0;
            mem_addr                 <= '0;
            mem_we                   <= 1'b0;
            mem_wstrb                <= 4'b0000;
            mem_wdata                <= '0;
            off_q                    <= 2'b00;
            funct3_q                 <= 3'b000;
        end else if (capture_c) begin
            program_count_out        <= program_count_in;
            program_count_valid_out  <= program_count_valid_in;
            write_register_out       <= write_register_in;
            write_register_valid_out <= write_register_valid_in;
            write_data_out           <= result_data_in;
            write_data_valid_out     <= (load_in || store_in) ? 1'b0 : result_data_valid_in;
            mem_addr                 <= ADDR_WIDTH'(result_data_in) & ~ADDR_WIDTH'(3);
            mem_we                   <= to_bus_c && store_in;
            mem_wstrb                <= to_bus_c ? ls_strobe(funct_3_in, off_eff_c) : 4'b0000;
            mem_wdata                <= (to_bus_c && store_in) ? DATA_WIDTH'(wdata_c) : '0;
            off_q                    <= off_eff_c;
            funct3_q                 <= funct_3_in;
        end else if ((state == RESPONSE) && mem_rvalid) begin
            write_data_out           <= load_value_c;
            write_data_valid_out     <= 1'b1;
        end
    end

endmodule
